// File: rtl/rv32i_types.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_types : shared RV32I encodings, instruction layout and the   |
// |               multi-cycle controller state / select enumerations.  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    // R-type field layout; immediates of other formats overlay these bits.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PCSEL_PC4     = 2'd0,
        PCSEL_PC_IMM  = 2'd1,
        PCSEL_RS1_IMM = 2'd2
    } pc_sel_t;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_CMP  = 3'd1,
        WB_UIMM = 3'd2,
        WB_PC4  = 3'd3,
        WB_LOAD = 3'd4
    } wb_sel_t;

    localparam logic [6:0] c_FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] c_FUNCT7_ALT  = 7'b0100000;

    function automatic logic is_legal(input instr_t i);
        logic ok;
        ok = 1'b0;
        case (i.opcode)
            op_lui, op_auipc, op_jal: ok = 1'b1;
            op_jalr:  ok = (i.funct3 == 3'b000);
            op_br:    ok = (i.funct3 != 3'b010) && (i.funct3 != 3'b011);
            op_load:  ok = (i.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            op_store: ok = (i.funct3 inside {3'b000, 3'b001, 3'b010});
            op_imm: begin
                if (i.funct3 == 3'b001)
                    ok = (i.funct7 == c_FUNCT7_BASE);
                else if (i.funct3 == 3'b101)
                    ok = (i.funct7 == c_FUNCT7_BASE) || (i.funct7 == c_FUNCT7_ALT);
                else
                    ok = 1'b1;
            end
            op_reg: ok = (i.funct7 == c_FUNCT7_BASE) ||
                         ((i.funct7 == c_FUNCT7_ALT) &&
                          ((i.funct3 == 3'b000) || (i.funct3 == 3'b101)));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_mask_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_mask_gen : byte-lane strobe and alignment check for a load or  |
// |                store, from funct3 width and the address low bits.  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module mem_mask_gen (
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lsb,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: mask = 4'b0001 << addr_lsb;
            2'b01: begin
                mask       = 4'b0011 << addr_lsb;
                misaligned = addr_lsb[0];
            end
            2'b10: begin
                mask       = 4'b1111;
                misaligned = |addr_lsb;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_mc_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_mc_control : multi-cycle RV32I controller (fetch, decode,    |
// |                    execute, memory, writeback, absorbing trap).    |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module rv32i_mc_control
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    input  logic        br_taken,
    input  logic [1:0]  addr_lsb,
    output instr_t      ir,
    output logic        mem_addr_sel,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic        pc_we,
    output logic        regf_we,
    output logic        retire,
    output pc_sel_t     pc_sel,
    output wb_sel_t     wb_sel,
    output logic        trap
);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    instr_t      r_ir;
    logic [3:0]  r_mask;
    logic [3:0]  w_mask;
    logic        w_misaligned;
    logic        w_is_load;
    logic        w_is_store;

    assign w_is_load  = (r_ir.opcode == op_load);
    assign w_is_store = (r_ir.opcode == op_store);
    assign ir         = r_ir;

    mem_mask_gen u_mask (
        .funct3     (r_ir.funct3),
        .addr_lsb   (addr_lsb),
        .mask       (w_mask),
        .misaligned (w_misaligned)
    );

    // Mask is captured in EXECUTE so MEMORY holds it even if the address moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_FETCH) && mem_resp)
                r_ir <= mem_rdata;
            if (r_state == ST_EXECUTE)
                r_mask <= w_mask;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_addr_sel = 1'b0;
        mem_rmask    = 4'b0000;
        mem_wmask    = 4'b0000;
        pc_we        = 1'b0;
        regf_we      = 1'b0;
        retire       = 1'b0;
        pc_sel       = PCSEL_PC4;
        wb_sel       = WB_ALU;
        trap         = 1'b0;
        // Outputs are gated by rst so strobes drop without waiting for a clock.
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_rmask = 4'b1111;
                    if (mem_resp)
                        w_next_state = ST_DECODE;
                end
                ST_DECODE: begin
                    w_next_state = is_legal(r_ir) ? ST_EXECUTE : ST_TRAP;
                end
                ST_EXECUTE: begin
                    if (w_is_load || w_is_store)
                        w_next_state = w_misaligned ? ST_TRAP : ST_MEMORY;
                    else
                        w_next_state = ST_WRITEBACK;
                end
                ST_MEMORY: begin
                    mem_addr_sel = 1'b1;
                    if (w_is_store)
                        mem_wmask = r_mask;
                    else
                        mem_rmask = r_mask;
                    if (mem_resp) begin
                        if (w_is_store) begin
                            pc_we        = 1'b1;
                            retire       = 1'b1;
                            w_next_state = ST_FETCH;
                        end else begin
                            w_next_state = ST_WRITEBACK;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    pc_we        = 1'b1;
                    retire       = 1'b1;
                    regf_we      = (r_ir.rd != 5'd0) && (r_ir.opcode != op_br) && !w_is_store;
                    w_next_state = ST_FETCH;
                    case (r_ir.opcode)
                        op_jal:  pc_sel = PCSEL_PC_IMM;
                        op_jalr: pc_sel = PCSEL_RS1_IMM;
                        op_br:   pc_sel = br_taken ? PCSEL_PC_IMM : PCSEL_PC4;
                        default: pc_sel = PCSEL_PC4;
                    endcase
                    case (r_ir.opcode)
                        op_lui:          wb_sel = WB_UIMM;
                        op_jal, op_jalr: wb_sel = WB_PC4;
                        op_load:         wb_sel = WB_LOAD;
                        op_imm, op_reg:  wb_sel = ((r_ir.funct3 == 3'b010) || (r_ir.funct3 == 3'b011))
                                                  ? WB_CMP : WB_ALU;
                        default:         wb_sel = WB_ALU;
                    endcase
                end
                ST_TRAP: trap = 1'b1;
                default: w_next_state = ST_TRAP;
            endcase
        end
    end

endmodule
`default_nettype wire
